// File: rtl/ativ1.sv
// Unsigned 2x2 array multiplier with a registered 4-bit product.
// The product is built from AND partial products and two half adders, then registered.
module ativ1 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] A,
  input  logic [1:0] B,
  output logic [3:0] Y1
);

  localparam int unsigned OpW   = 2;
  localparam int unsigned ProdW = 4;

  logic [OpW-1:0]   a_c;
  logic [OpW-1:0]   b_c;
  logic             p00_c;
  logic             p01_c;
  logic             p10_c;
  logic             p11_c;
  logic             c1_c;
  logic [ProdW-1:0] prod_d;
  logic [ProdW-1:0] y1_q;

  assign a_c = A;
  assign b_c = B;

  // Partial products, then half adders ripple the middle-column carry upward
  always_comb begin
    p00_c     = a_c[0] & b_c[0];
    p01_c     = a_c[0] & b_c[1];
    p10_c     = a_c[1] & b_c[0];
    p11_c     = a_c[1] & b_c[1];
    c1_c      = p01_c & p10_c;
    prod_d    = '0;
    prod_d[0] = p00_c;
    prod_d[1] = p01_c ^ p10_c;
    prod_d[2] = p11_c ^ c1_c;
    prod_d[3] = p11_c & c1_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y1_q <= '0;
    end else begin
      y1_q <= prod_d;
    end
  end

  assign Y1 = y1_q;

endmodule

// File: tb/tb_ativ1.sv
// Scoreboard bench for ativ1: stimulus pushes expected products, a monitor pops and compares.
module tb_ativ1;

  logic       clk;
  logic       rst_n;
  logic [1:0] A;
  logic [1:0] B;
  logic [3:0] Y1;

  int unsigned checks;
  int unsigned errors;
  logic [3:0]  exp_q[$];
  logic [3:0]  last_exp;
  logic [3:0]  exp_tab [16] = '{4'd0, 4'd0, 4'd0, 4'd0,
                                 4'd0, 4'd1, 4'd2, 4'd3,
                                 4'd0, 4'd2, 4'd4, 4'd6,
                                 4'd0, 4'd3, 4'd6, 4'd9};

  ativ1 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .B     (B),
    .Y1    (Y1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  // Operands change on the falling edge; the rising edge after it loads the product
  task automatic drive(input logic [1:0] a, input logic [1:0] b, input logic [3:0] e);
    @(negedge clk);
    A = a;
    B = b;
    exp_q.push_back(e);
    last_exp = e;
  endtask

  // Monitor: every rising edge out of reset presents one result for the oldest entry
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && exp_q.size() > 0) begin
        check("product", Y1, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [3:0] idx;
    checks   = 0;
    errors   = 0;
    last_exp = 4'd0;
    A        = 2'd3;
    B        = 2'd3;
    rst_n    = 1'b0;

    // Reset held with 3x3 on the inputs while the clock runs
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_hold", Y1, 4'b0000);
    end

    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(4'b1001);
    last_exp = 4'b1001;

    for (int i = 0; i < 16; i++) begin
      idx = 4'(i);
      drive(idx[3:2], idx[1:0], exp_tab[i]);
    end

    drive(2'd1, 2'd2, 4'b0010);
    drive(2'd2, 2'd3, 4'b0110);
    drive(2'd3, 2'd3, 4'b1001);
    drive(2'd0, 2'd3, 4'b0000);
    drive(2'd3, 2'd0, 4'b0000);
    drive(2'd3, 2'd2, 4'b0110);
    drive(2'd3, 2'd3, 4'b1001);

    // Operands changed just after an edge must not reach Y1 until the next edge
    @(posedge clk);
    #2;
    A = 2'd2;
    B = 2'd2;
    exp_q.push_back(4'b0100);
    #2;
    check("latency_hold", Y1, last_exp);
    last_exp = 4'b0100;
    @(posedge clk);

    drive(2'd3, 2'd3, 4'b1001);
    drive(2'd1, 2'd3, 4'b0011);
    // Mid-cycle reset pulse clears at once; the next edge loads the current 1x3
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", Y1, 4'b0000);
    #1;
    rst_n = 1'b1;

    drive(2'd2, 2'd1, 4'b0010);
    drive(2'd1, 2'd1, 4'b0001);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d results never observed, expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
